// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single instruction-memory port between the
// fetch stage (reads) and the program loader (writes).
//
// After reset the core is held in BOOT and only the loader may write. The
// loader's final word starts a one-cycle FLUSH, after which both masters
// share the port in RUN with loader priority.
//
// Optional feature: define IMEM_ARB_FAIR_EN to add a starvation counter
// that forces one fetch through after STARVE_MAX consecutive contended
// loader grants. Without it, the loader has strict priority in RUN.
module imem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // fetch side
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic              f_gnt_o,
  output logic              f_rvalid_o,
  output logic [DATA_W-1:0] f_rdata_o,
  output logic              stall_o,
  output logic              flush_o,
  // loader side
  input  logic              l_req_i,
  input  logic [ADDR_W-1:0] l_addr_i,
  input  logic [DATA_W-1:0] l_wdata_i,
  input  logic              l_last_i,
  output logic              l_gnt_o,
  output logic              l_err_o,
  output logic [CNT_W-1:0]  words_o,
  // memory side
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               f_rvalid_q;
  logic [DATA_W-1:0]  f_rdata_q;
  logic               flush_q;
  logic               l_err_q;
  logic [CNT_W-1:0]   words_q, words_d;

  logic               f_gnt;
  logic               l_gnt;
  logic               l_aligned;
  logic               contended;
  logic               starve_hit;

  assign l_aligned = (l_addr_i[1:0] == 2'b00);
  assign contended = f_req_i && l_req_i;

`ifdef IMEM_ARB_FAIR_EN
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;

  assign starve_hit = (starve_q == SW'(STARVE_MAX));

  // Starvation counter: counts contended loader wins in RUN, clears on any
  // fetch grant and whenever RUN is left or not yet entered.
  always_comb begin
    starve_d = starve_q;
    if (state_q != RUN || state_d != RUN) begin
      starve_d = '0;
    end else if (f_gnt) begin
      starve_d = '0;
    end else if (l_gnt && f_req_i && !starve_hit) begin
      starve_d = starve_q + SW'(1);
    end
  end
`else
  // Strict priority: fetch is never forced through; STARVE_MAX has no
  // effect in this build and the comparison below is always false.
  assign starve_hit = (STARVE_MAX < 0);
`endif

  // Grant decision and next state, both from current state and requests.
  always_comb begin
    f_gnt   = 1'b0;
    l_gnt   = 1'b0;
    state_d = state_q;
    case (state_q)
      BOOT: begin
        l_gnt = l_req_i;
        if (l_gnt && l_last_i) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = RUN;
      end
      RUN: begin
        if (contended && starve_hit) begin
          f_gnt = 1'b1;
        end else begin
          l_gnt = l_req_i;
          f_gnt = f_req_i && !l_req_i;
        end
        if (l_gnt && l_last_i) begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Loaded-word counter: clears at the end of FLUSH, otherwise counts
  // aligned accepted writes and sticks at all-ones.
  always_comb begin
    words_d = words_q;
    if (state_q == FLUSH) begin
      words_d = '0;
    end else if (l_gnt && l_aligned && (words_q != {CNT_W{1'b1}})) begin
      words_d = words_q + CNT_W'(1);
    end
  end

  // FSM state and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      f_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      flush_q    <= 1'b0;
      l_err_q    <= 1'b0;
      words_q    <= '0;
`ifdef IMEM_ARB_FAIR_EN
      starve_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      f_rvalid_q <= f_gnt;
      if (f_gnt) begin
        f_rdata_q <= mem_rdata_i;
      end
      flush_q    <= (state_d == FLUSH);
      l_err_q    <= l_gnt && !l_aligned;
      words_q    <= words_d;
`ifdef IMEM_ARB_FAIR_EN
      starve_q   <= starve_d;
`endif
    end
  end

  // Memory port mux: the loader owns the port whenever it is granted.
  always_comb begin
    mem_addr_o  = f_addr_i;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    if (l_gnt) begin
      mem_addr_o  = l_addr_i;
      mem_we_o    = l_aligned;
      mem_wdata_o = l_wdata_i;
    end
  end

  assign f_gnt_o    = f_gnt;
  assign l_gnt_o    = l_gnt;
  assign stall_o    = f_req_i && !f_gnt;
  assign f_rvalid_o = f_rvalid_q;
  assign f_rdata_o  = f_rdata_q;
  assign flush_o    = flush_q;
  assign l_err_o    = l_err_q;
  assign words_o    = words_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed boot/run scenarios followed by random traffic,
// all compared every cycle against a transaction-level reference model.
// Honours IMEM_ARB_FAIR_EN the same way the design does.
module tb_imem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 8;
  localparam int CNT_W      = 16;

`ifdef IMEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  typedef enum {M_BOOT, M_FLUSH, M_RUN} phase_e;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fReq;
  logic [ADDR_W-1:0] fAddr;
  logic              fGnt;
  logic              fRvalid;
  logic [DATA_W-1:0] fRdata;
  logic              stall;
  logic              flush;
  logic              lReq;
  logic [ADDR_W-1:0] lAddr;
  logic [DATA_W-1:0] lWdata;
  logic              lLast;
  logic              lGnt;
  logic              lErr;
  logic [CNT_W-1:0]  words;
  logic [ADDR_W-1:0] memAddr;
  logic              memWe;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] memRdata;

  // harness memory: combinational read, write on rising edge
  bit [DATA_W-1:0] harnessMem [256];

  // reference model state
  phase_e          mPhase;
  bit              mRvalid;
  bit [DATA_W-1:0] mRdata;
  bit              mErr;
  int              mWords;
  int              mStreak;
  bit [DATA_W-1:0] mMem [256];

  int total = 0;
  int bad   = 0;
  bit obsFGnt;
  bit [19:0] gntMask;

  always #5 clk = ~clk;

  imem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .f_req_i(fReq),
    .f_addr_i(fAddr),
    .f_gnt_o(fGnt),
    .f_rvalid_o(fRvalid),
    .f_rdata_o(fRdata),
    .stall_o(stall),
    .flush_o(flush),
    .l_req_i(lReq),
    .l_addr_i(lAddr),
    .l_wdata_i(lWdata),
    .l_last_i(lLast),
    .l_gnt_o(lGnt),
    .l_err_o(lErr),
    .words_o(words),
    .mem_addr_o(memAddr),
    .mem_we_o(memWe),
    .mem_wdata_o(memWdata),
    .mem_rdata_i(memRdata)
  );

  // instruction memory behind the arbiter
  assign memRdata = harnessMem[memAddr[9:2]];

  always @(posedge clk) begin
    if (memWe) harnessMem[memAddr[9:2]] <= memWdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPhase  = M_BOOT;
    mRvalid = 1'b0;
    mRdata  = '0;
    mErr    = 1'b0;
    mWords  = 0;
    mStreak = 0;
  endtask

  task automatic applyStimulus(input bit fr, input logic [31:0] fa, input bit lr,
                               input logic [31:0] la, input logic [31:0] lw, input bit ll);
    fReq   = fr;
    fAddr  = fa;
    lReq   = lr;
    lAddr  = la;
    lWdata = lw;
    lLast  = ll;
  endtask

  // Checks one cycle against the model, then advances model and clock.
  task automatic checkOutput(input string tag);
    bit expF, expL, misal;
    #1;
    expF  = 1'b0;
    expL  = 1'b0;
    misal = (lAddr[1:0] != 2'b00);
    case (mPhase)
      M_BOOT:  expL = lReq;
      M_FLUSH: ;
      M_RUN: begin
        if (FAIR && fReq && lReq && mStreak == STARVE_MAX) begin
          expF = 1'b1;
        end else begin
          expL = lReq;
          expF = fReq && !lReq;
        end
      end
    endcase
    obsFGnt = fGnt;
    chk($sformatf("%s.f_gnt", tag), fGnt, expF);
    chk($sformatf("%s.l_gnt", tag), lGnt, expL);
    chk($sformatf("%s.stall", tag), stall, fReq && !expF);
    chk($sformatf("%s.mem_we", tag), memWe, expL && !misal);
    chk($sformatf("%s.mem_addr", tag), memAddr, expL ? lAddr : fAddr);
    chk($sformatf("%s.mem_wdata", tag), memWdata, expL ? lWdata : 32'h0);
    chk($sformatf("%s.f_rvalid", tag), fRvalid, mRvalid);
    chk($sformatf("%s.f_rdata", tag), fRdata, mRdata);
    chk($sformatf("%s.flush", tag), flush, mPhase == M_FLUSH);
    chk($sformatf("%s.l_err", tag), lErr, mErr);
    chk($sformatf("%s.words", tag), words, mWords[CNT_W-1:0]);
    @(posedge clk);
    mRvalid = expF;
    if (expF) mRdata = mMem[fAddr[9:2]];
    mErr = expL && misal;
    if (expL && !misal) begin
      mMem[lAddr[9:2]] = lWdata;
      if (mWords < (1 << CNT_W) - 1) mWords++;
    end
    if (mPhase == M_RUN && fReq && lReq && expL) mStreak++;
    if (expF) mStreak = 0;
    if (mPhase == M_FLUSH) begin
      mPhase = M_RUN;
      mWords = 0;
    end else if (expL && lLast) begin
      mPhase  = M_FLUSH;
      mStreak = 0;
    end
    @(negedge clk);
  endtask

  task automatic step(input bit fr, input logic [31:0] fa, input bit lr, input logic [31:0] la,
                      input logic [31:0] lw, input bit ll, input string tag);
    applyStimulus(fr, fa, lr, la, lw, ll);
    checkOutput(tag);
  endtask

  initial begin
    logic [31:0] ra;
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    modelReset();
    #2;
    chk("rst.f_rvalid", fRvalid, 1'b0);
    chk("rst.f_rdata", fRdata, 32'h0);
    chk("rst.flush", flush, 1'b0);
    chk("rst.l_err", lErr, 1'b0);
    chk("rst.words", words, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] boot load");

    // boot image of three words with fetch already requesting
    step(1, 32'h0, 1, 32'h0, 32'h13, 0, "boot0");
    step(1, 32'h0, 1, 32'h4, 32'h13, 0, "boot1");
    step(1, 32'h0, 1, 32'h8, 32'h13, 1, "boot2");
    chk("flush.words3", words, 16'd3);
    step(1, 32'h0, 0, 32'h0, 32'h0, 0, "flush");
    chk("run.words0", words, 16'd0);
    step(1, 32'h0, 0, 32'h0, 32'h0, 0, "run_f0");
    chk("run.first_rdata", fRdata, 32'h13);

    // back-to-back fetches
    step(1, 32'h0, 0, 32'h0, 32'h0, 0, "bb0");
    step(1, 32'h4, 0, 32'h0, 32'h0, 0, "bb1");
    step(1, 32'h8, 0, 32'h0, 32'h0, 0, "bb2");
    step(0, 32'h0, 0, 32'h0, 32'h0, 0, "bb_idle");

    // misaligned write leaves 0x4 untouched
    step(0, 32'h0, 1, 32'h6, 32'hDEADBEEF, 0, "mis");
    chk("mis.l_err_pulse", lErr, 1'b1);
    step(1, 32'h4, 0, 32'h0, 32'h0, 0, "mis_f4");
    step(0, 32'h0, 0, 32'h0, 32'h0, 0, "mis_chk");
    chk("mis.mem4_kept", fRdata, 32'h13);

    // sustained contention right after a fetch grant
    step(1, 32'h4, 0, 32'h0, 32'h0, 0, "pre_cont");
    gntMask = '0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 32'h10, 1, 32'h100 + 32'(4 * i), $urandom, 0);
      checkOutput($sformatf("cont%0d", i));
      gntMask[i] = obsFGnt;
    end
    chk("cont.fgnt_mask", gntMask, FAIR ? 20'h20100 : 20'h00000);

    // asynchronous reset in the middle of a fetch
    step(1, 32'h8, 0, 32'h0, 32'h0, 0, "pre_rst");
    #1 rst_n = 1'b0;
    #1;
    chk("arst.f_rvalid", fRvalid, 1'b0);
    chk("arst.f_gnt", fGnt, 1'b0);
    chk("arst.stall", stall, 1'b1);
    chk("arst.words", words, 16'h0);
    modelReset();
    #1 rst_n = 1'b1;
    step(1, 32'h8, 0, 32'h0, 32'h0, 0, "boot_again");
    step(1, 32'h20, 1, 32'h20, 32'hA5A5_0001, 1, "boot_last");
    step(1, 32'h20, 0, 32'h0, 32'h0, 0, "flush2");
    step(1, 32'h20, 0, 32'h0, 32'h0, 0, "run2");

    // last word while fetch is requesting
    step(1, 32'h20, 1, 32'h24, 32'hA5A5_0002, 1, "run_last");
    chk("run_last.no_fgnt", obsFGnt, 1'b0);
    step(1, 32'h24, 0, 32'h0, 32'h0, 0, "flush3");
    step(1, 32'h24, 0, 32'h0, 32'h0, 0, "after_flush");
    chk("after_flush.fgnt", obsFGnt, 1'b1);

    // random traffic
    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      ra = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) != 0) ra[1:0] = 2'b00;
      applyStimulus($urandom_range(0, 1) == 1, 32'($urandom_range(0, 1023)),
                    $urandom_range(0, 2) == 0, ra, $urandom,
                    $urandom_range(0, 15) == 0);
      checkOutput($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Sequences and shares the single instruction-memory port between the pipeline fetch stage (read) and the program loader (write). After reset it holds the core in a BOOT phase where only the loader may write. The final loader word triggers a one-cycle pipeline flush, after which fetch and loader share the port under loader priority. It sits between the IF stage / boot loader and the combinational-read instruction memory.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, word width
- STARVE_MAX, 8, consecutive contended loader grants before fetch is forced through (only with IMEM_ARB_FAIR_EN)
- CNT_W, 16, width of loaded-word counter

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- f_req_i  in  1  fetch read request
- f_addr_i  in  ADDR_W  fetch byte address
- f_gnt_o  out  1  fetch granted this cycle
- f_rvalid_o  out  1  f_rdata_o valid (registered)
- f_rdata_o  out  DATA_W  fetched instruction (registered)
- stall_o  out  1  f_req_i && !f_gnt_o
- flush_o  out  1  one-cycle pipeline restart pulse (registered)
- l_req_i  in  1  loader write request
- l_addr_i  in  ADDR_W  loader byte address
- l_wdata_i  in  DATA_W  loader write data
- l_last_i  in  1  qualifies l_req_i: final word of an image
- l_gnt_o  out  1  loader write accepted this cycle
- l_err_o  out  1  one-cycle pulse: previous granted write was misaligned (registered)
- words_o  out  CNT_W  words written since last flush (registered)
- mem_addr_o  out  ADDR_W  memory byte address (memory indexes [ADDR_W-1:2])
- mem_we_o  out  1  memory write enable
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  combinational memory read data

## Operation
- FSM states: BOOT, FLUSH, RUN. Reset state BOOT.
- BOOT: f_gnt_o=0; l_gnt_o=l_req_i. Granted write with l_last_i -> FLUSH.
- FLUSH: exactly one cycle; no grants; flush_o=1; words_o cleared at its end -> RUN.
- RUN: if only one requester, it is granted. If both, the loader wins (see Configuration). Granted write with l_last_i -> FLUSH; fetch is not granted in that cycle.
- Port mux: loader granted -> mem_addr_o=l_addr_i, mem_wdata_o=l_wdata_i, mem_we_o=1 unless l_addr_i[1:0]!=0. Otherwise mem_addr_o=f_addr_i, mem_we_o=0, mem_wdata_o=0.
- Misaligned write: l_gnt_o still asserted, memory not written, l_err_o pulses next cycle, words_o not incremented. l_last_i is still honoured.
- words_o increments on each aligned granted write and saturates at all-ones.
- Reset (any time, async): state BOOT, all registered outputs 0, starvation counter 0. An in-flight fetch response is discarded.

## Timing
- f_gnt_o, l_gnt_o, stall_o, mem_* are combinational from state and requests in the same cycle.
- Fetch latency 1: mem_rdata_i is captured at the edge ending a granted fetch cycle. f_rvalid_o=1 and f_rdata_o are valid the next cycle. Back-to-back grants give one word per cycle.
- f_rvalid_o=0 in any cycle following a non-granted fetch cycle. f_rdata_o holds its last value.
- Loader write commits at the edge ending the l_gnt_o cycle.
- flush_o is high during the FLUSH cycle only; the first RUN grant is possible the following cycle.
- Reset values: f_rvalid_o=0, f_rdata_o=0, flush_o=0, l_err_o=0, words_o=0. Combinational outputs follow BOOT rules.

## Configuration
- IMEM_ARB_FAIR_EN defined: a starvation counter (0..STARVE_MAX) increments each RUN cycle where both requesters are active and the loader is granted.
  - When the counter equals STARVE_MAX, the next contended cycle grants fetch instead and clears the counter.
  - The counter also clears on any fetch grant and on leaving RUN.
- IMEM_ARB_FAIR_EN undefined: strict loader priority in RUN. No counter is present; fetch can starve indefinitely.

## Test plan
- Reset then f_req_i=1 held, loader writes 0x13 to 0x0, 0x4, 0x8 (last on 0x8): stall_o=1 throughout BOOT, flush_o=1 for exactly one cycle, words_o=3 during FLUSH then 0. First fetch of 0x0 gives f_rdata_o=0x13 with f_rvalid_o one cycle after grant.
- RUN, fetch 0x0,0x4,0x8 on consecutive cycles: f_gnt_o=1 every cycle, f_rvalid_o=1 for three cycles with matching data, 1-cycle latency.
- RUN, loader write to 0x6: l_gnt_o=1, mem_we_o=0, l_err_o=1 next cycle, words_o unchanged, memory at 0x4 unchanged.
- RUN, both requesting continuously for 20 cycles, STARVE_MAX=8:
  - With IMEM_ARB_FAIR_EN: f_gnt_o=1 on cycles 9 and 18.
  - Without it: f_gnt_o=0 all 20 cycles.
- rst_ni pulsed low mid-fetch in RUN: f_rvalid_o=0 immediately, state BOOT (f_gnt_o=0 with f_req_i=1, stall_o=1), words_o=0.
- RUN, loader write with l_last_i while f_req_i=1: l_gnt_o=1, f_gnt_o=0, then flush_o=1 next cycle, fetch granted the cycle after.
